// File: rtl/vga_timing_detect.sv
// vga_timing_detect
// Sink-side video timing monitor. Measures horizontal and vertical timing
// of an incoming hsync/vsync/de stream, publishes a snapshot once per frame,
// declares lock after a run of identical clean frames, and regenerates
// de-aligned pixel coordinates for capture logic.

module vga_timing_detect #(
   parameter int W           = 12,
   parameter int HS_POL      = 0,
   parameter int VS_POL      = 0,
   parameter int LOCK_FRAMES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hsync,
   input  logic         vsync,
   input  logic         de,
   output logic [W-1:0] h_total,
   output logic [W-1:0] h_active,
   output logic [W-1:0] h_sync,
   output logic [W-1:0] v_total,
   output logic [W-1:0] v_active,
   output logic [W-1:0] v_sync,
   output logic         locked,
   output logic         frame_start,
   output logic         de_o,
   output logic [W-1:0] x,
   output logic [W-1:0] y
);

   localparam logic [W-1:0] MAXV = '1;
   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ZERO = '0;

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == MAXV) ? v : v + ONE;
   endfunction

   logic hs_n, vs_n;
   logic hs1, vs1, de1, hs2, vs2;
   logic hs_edge, vs_edge;

   logic [W-1:0] pix_cnt, hs_cnt, de_cnt;
   logic [W-1:0] line_total, line_active, line_sync;
   logic [W-1:0] ln_cnt, act_ln, vs_ln;
   logic         line_err, ovf, first_line, started;
   logic         pub_q, match_q, fell_line;

   logic [W-1:0] pix_nxt, hs_cnt_nxt, de_cnt_nxt;
   logic [W-1:0] lt_nxt, la_nxt, ls_nxt;
   logic [W-1:0] ln_nxt, act_nxt, vsl_nxt;
   logic         err_nxt, ovf_nxt, match_c;

   state_t       state, state_nxt;
   logic [3:0]   good, good_nxt;

   assign hs_n    = (HS_POL != 0) ? hsync : ~hsync;
   assign vs_n    = (VS_POL != 0) ? vsync : ~vsync;
   assign hs_edge = hs1 & ~hs2;
   assign vs_edge = vs1 & ~vs2;
   assign locked  = (state == LOCKED);

   // Two-stage input pipeline with syncs normalized to active-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs1 <= 1'b0;
         vs1 <= 1'b0;
         de1 <= 1'b0;
         hs2 <= 1'b0;
         vs2 <= 1'b0;
      end else begin
         hs1 <= hs_n;
         vs1 <= vs_n;
         de1 <= de;
         hs2 <= hs1;
         vs2 <= vs1;
      end
   end

   // Next values of all line/frame counters; a line closing in the same
   // clock as a frame edge is folded in before the frame snapshot is taken.
   always_comb begin
      pix_nxt    = hs_edge ? ONE : sat_inc(pix_cnt);
      hs_cnt_nxt = hs_edge ? ONE : (hs1 ? sat_inc(hs_cnt) : hs_cnt);
      de_cnt_nxt = hs_edge ? {{(W-1){1'b0}}, de1} : (de1 ? sat_inc(de_cnt) : de_cnt);
      lt_nxt     = hs_edge ? pix_cnt : line_total;
      ls_nxt     = hs_edge ? hs_cnt : line_sync;
      la_nxt     = (hs_edge && de_cnt != ZERO) ? de_cnt : line_active;
      ln_nxt     = hs_edge ? sat_inc(ln_cnt) : ln_cnt;
      act_nxt    = (hs_edge && de_cnt != ZERO) ? sat_inc(act_ln) : act_ln;
      vsl_nxt    = (hs_edge && vs1) ? sat_inc(vs_ln) : vs_ln;
      err_nxt    = line_err | (hs_edge && !first_line && (pix_cnt != line_total));
      ovf_nxt    = ovf | (pix_cnt == MAXV) | (hs_cnt == MAXV) | (de_cnt == MAXV)
                       | (ln_cnt == MAXV) | (act_ln == MAXV) | (vs_ln == MAXV);
      match_c    = ({lt_nxt, la_nxt, ls_nxt, ln_nxt, act_nxt, vsl_nxt} ==
                    {h_total, h_active, h_sync, v_total, v_active, v_sync})
                   && !err_nxt && !ovf_nxt;
   end

   // Per-line measurements; the line right after a frame edge is exempt
   // from the line-to-line length comparison.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt     <= ZERO;
         hs_cnt      <= ZERO;
         de_cnt      <= ZERO;
         line_total  <= ZERO;
         line_active <= ZERO;
         line_sync   <= ZERO;
         first_line  <= 1'b1;
      end else begin
         pix_cnt     <= pix_nxt;
         hs_cnt      <= hs_cnt_nxt;
         de_cnt      <= de_cnt_nxt;
         line_total  <= lt_nxt;
         line_active <= la_nxt;
         line_sync   <= ls_nxt;
         if (vs_edge)
            first_line <= 1'b1;
         else if (hs_edge)
            first_line <= 1'b0;
      end
   end

   // Frame counters and snapshot publication; the first frame edge after
   // reset only arms measurement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ln_cnt      <= ZERO;
         act_ln      <= ZERO;
         vs_ln       <= ZERO;
         line_err    <= 1'b0;
         ovf         <= 1'b0;
         started     <= 1'b0;
         pub_q       <= 1'b0;
         match_q     <= 1'b0;
         frame_start <= 1'b0;
         h_total     <= ZERO;
         h_active    <= ZERO;
         h_sync      <= ZERO;
         v_total     <= ZERO;
         v_active    <= ZERO;
         v_sync      <= ZERO;
      end else begin
         frame_start <= vs_edge;
         pub_q       <= vs_edge & started;
         if (vs_edge) begin
            if (started) begin
               h_total  <= lt_nxt;
               h_active <= la_nxt;
               h_sync   <= ls_nxt;
               v_total  <= ln_nxt;
               v_active <= act_nxt;
               v_sync   <= vsl_nxt;
            end
            match_q  <= match_c;
            started  <= 1'b1;
            ln_cnt   <= ZERO;
            act_ln   <= ZERO;
            vs_ln    <= ZERO;
            line_err <= 1'b0;
            ovf      <= 1'b0;
         end else begin
            ln_cnt   <= ln_nxt;
            act_ln   <= act_nxt;
            vs_ln    <= vsl_nxt;
            line_err <= err_nxt;
            ovf      <= ovf_nxt;
         end
      end
   end

   // Lock state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEARCH;
         good  <= 4'd0;
      end else begin
         state <= state_nxt;
         good  <= good_nxt;
      end
   end

   // Lock decisions are taken the cycle after each published snapshot; a
   // frame that never ends drops straight back to searching.
   always_comb begin
      state_nxt = state;
      good_nxt  = good;
      if (ln_cnt == MAXV) begin
         state_nxt = SEARCH;
         good_nxt  = 4'd0;
      end else if (pub_q) begin
         unique case (state)
            SEARCH: begin
               state_nxt = TRACK;
               good_nxt  = 4'd0;
            end
            TRACK: begin
               if (match_q) begin
                  good_nxt = good + 4'd1;
                  if ((good + 4'd1) >= 4'(LOCK_FRAMES))
                     state_nxt = LOCKED;
               end else begin
                  good_nxt = 4'd0;
               end
            end
            LOCKED: begin
               if (!match_q) begin
                  state_nxt = TRACK;
                  good_nxt  = 4'd0;
               end
            end
            default: begin
               state_nxt = SEARCH;
               good_nxt  = 4'd0;
            end
         endcase
      end
   end

   // Pixel coordinates aligned with de_o; de_o doubles as the previous de1
   // for edge detection, and y advances once per active line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_o      <= 1'b0;
         x         <= ZERO;
         y         <= ZERO;
         fell_line <= 1'b0;
      end else begin
         de_o <= de1;
         if (de1 && !de_o)
            x <= ZERO;
         else if (de1)
            x <= sat_inc(x);
         if (vs_edge)
            y <= ZERO;
         else if (de_o && !de1 && !fell_line)
            y <= sat_inc(y);
         if (hs_edge)
            fell_line <= 1'b0;
         else if (de_o && !de1)
            fell_line <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_timing_detect.sv
// tb_vga_timing_detect
// Directed bench on a reduced video format: 40-clock lines (24 active,
// 4 front porch, 6 sync, 6 back porch) and 20-line frames (12 active,
// 2 front porch, 3 sync, 3 back porch). dut1 uses default active-low syncs
// and W=12; dut2 sees the same stream with active-high syncs and W=8 so the
// missing-vsync timeout is reachable in a short run.

module tb_vga_timing_detect;

   localparam int W1 = 12;
   localparam int W2 = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic hs_a = 1'b0;
   logic vs_a = 1'b0;
   logic de_a = 1'b0;

   logic fs_mark = 1'b0;
   int   px_i = 0;
   int   ln_i = 0;

   logic [W1-1:0] h_total1, h_active1, h_sync1, v_total1, v_active1, v_sync1, x1, y1;
   logic          locked1, fs1, de_o1;
   logic [W2-1:0] h_total2, h_active2, h_sync2, v_total2, v_active2, v_sync2, x2, y2;
   logic          locked2, fs2, de_o2;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   logic pde1 = 1'b0, pde2 = 1'b0, pfs1 = 1'b0, pfs2 = 1'b0;
   int   px1 = 0, px2 = 0, ln1 = 0, ln2 = 0;

   vga_timing_detect #(.W(W1), .HS_POL(0), .VS_POL(0), .LOCK_FRAMES(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .hsync(~hs_a), .vsync(~vs_a), .de(de_a),
      .h_total(h_total1), .h_active(h_active1), .h_sync(h_sync1),
      .v_total(v_total1), .v_active(v_active1), .v_sync(v_sync1),
      .locked(locked1), .frame_start(fs1), .de_o(de_o1), .x(x1), .y(y1)
   );

   vga_timing_detect #(.W(W2), .HS_POL(1), .VS_POL(1), .LOCK_FRAMES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .hsync(hs_a), .vsync(vs_a), .de(de_a),
      .h_total(h_total2), .h_active(h_active2), .h_sync(h_sync2),
      .v_total(v_total2), .v_active(v_active2), .v_sync(v_sync2),
      .locked(locked2), .frame_start(fs2), .de_o(de_o2), .x(x2), .y(y2)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one line of the reduced format, one pixel per falling edge.
   task automatic applyStimulus(input int len, input bit act, input bit vsa,
                                input bit vsrise, input int lidx);
      for (int p = 0; p < len; p++) begin
         @(negedge clk);
         de_a    = act && (p < 24);
         hs_a    = (p >= 28) && (p < 34);
         vs_a    = vsa;
         fs_mark = vsrise && (p == 0);
         px_i    = p;
         ln_i    = lidx;
      end
   endtask

   // Drive lines first..last of a frame; glitch shortens that line by one.
   task automatic sendFrame(input int first, input int last, input int glitch);
      for (int l = first; l <= last; l++)
         applyStimulus((l == glitch) ? 39 : 40, l < 12, (l >= 14) && (l < 17), l == 14, l);
   endtask

   task automatic checkLock(input string tag, input logic e1, input logic e2);
      checkOutput({tag, "_locked1"}, 32'(locked1), 32'(e1));
      checkOutput({tag, "_locked2"}, 32'(locked2), 32'(e2));
   endtask

   task automatic checkMeas(input string tag);
      checkOutput({tag, "_h_total1"},  32'(h_total1),  40);
      checkOutput({tag, "_h_active1"}, 32'(h_active1), 24);
      checkOutput({tag, "_h_sync1"},   32'(h_sync1),   6);
      checkOutput({tag, "_v_total1"},  32'(v_total1),  20);
      checkOutput({tag, "_v_active1"}, 32'(v_active1), 12);
      checkOutput({tag, "_v_sync1"},   32'(v_sync1),   3);
      checkOutput({tag, "_h_total2"},  32'(h_total2),  40);
      checkOutput({tag, "_h_active2"}, 32'(h_active2), 24);
      checkOutput({tag, "_h_sync2"},   32'(h_sync2),   6);
      checkOutput({tag, "_v_total2"},  32'(v_total2),  20);
      checkOutput({tag, "_v_active2"}, 32'(v_active2), 12);
      checkOutput({tag, "_v_sync2"},   32'(v_sync2),   3);
   endtask

   // Expected de_o / frame_start / coordinates: the stimulus delayed two clocks.
   always @(posedge clk) begin
      pde1 <= de_a;
      pde2 <= pde1;
      pfs1 <= fs_mark;
      pfs2 <= pfs1;
      px1  <= px_i;
      px2  <= px1;
      ln1  <= ln_i;
      ln2  <= ln1;
   end

   // Streaming comparison of the aligned outputs while enabled.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("de_o", 32'(de_o1), 32'(pde2));
         checkOutput("frame_start", 32'(fs1), 32'(pfs2));
         checkOutput("de_o_pol", 32'(de_o2), 32'(pde2));
         if (pde2) begin
            checkOutput("x", 32'(x1), 32'(px2));
            checkOutput("y", 32'(y1), 32'(ln2));
         end
      end
   end

   initial begin
      $display("[TB] start");
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_locked", 32'(locked1), 0);
      checkOutput("rst_h_total", 32'(h_total1), 0);
      checkOutput("rst_v_total", 32'(v_total1), 0);
      checkOutput("rst_frame_start", 32'(fs1), 0);
      checkOutput("rst_de_o", 32'(de_o1), 0);
      checkOutput("rst_x", 32'(x1), 0);
      checkOutput("rst_y", 32'(y1), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Initial lock: the fourth vsync edge after reset locks.
      chk_en = 1'b1;
      sendFrame(0, 19, -1);
      checkOutput("f1_v_total_discarded", 32'(v_total1), 0);
      sendFrame(0, 19, -1);
      checkOutput("f2_v_total", 32'(v_total1), 20);
      sendFrame(0, 19, -1);
      checkLock("f3", 1'b0, 1'b0);
      sendFrame(0, 19, -1);
      checkLock("f4", 1'b1, 1'b1);
      checkMeas("f4");
      chk_en = 1'b0;

      // One short line breaks lock; two clean frames restore it.
      sendFrame(0, 19, 5);
      checkLock("glitch", 1'b0, 1'b0);
      checkOutput("glitch_h_total", 32'(h_total1), 40);
      sendFrame(0, 19, -1);
      checkLock("glitch_g1", 1'b0, 1'b0);
      sendFrame(0, 19, -1);
      checkLock("glitch_g2", 1'b1, 1'b1);

      // Missing vsync: the 8-bit instance saturates its line count and
      // drops lock; the 12-bit one has not reached its limit yet.
      for (int i = 0; i < 260; i++)
         applyStimulus(40, 1'b0, 1'b0, 1'b0, 0);
      checkLock("timeout", 1'b1, 1'b0);
      sendFrame(0, 19, -1);
      sendFrame(0, 19, -1);
      sendFrame(0, 19, -1);
      checkLock("relock3", 1'b0, 1'b0);
      sendFrame(0, 19, -1);
      checkLock("relock4", 1'b1, 1'b1);
      checkMeas("relock");

      // Asynchronous reset in the middle of a locked frame.
      sendFrame(0, 6, -1);
      #2 rst_n = 1'b0;
      #1;
      checkLock("midrst", 1'b0, 1'b0);
      checkOutput("midrst_h_total", 32'(h_total1), 0);
      checkOutput("midrst_v_active", 32'(v_active1), 0);
      checkOutput("midrst_h_sync2", 32'(h_sync2), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sendFrame(7, 19, -1);
      checkOutput("post_e1_v_total", 32'(v_total1), 0);
      sendFrame(0, 19, -1);
      checkOutput("post_e2_v_total", 32'(v_total1), 20);
      checkLock("post_e2", 1'b0, 1'b0);
      sendFrame(0, 19, -1);
      checkLock("post_e3", 1'b0, 1'b0);
      sendFrame(0, 19, -1);
      checkLock("post_e4", 1'b1, 1'b1);
      checkMeas("post");

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_detect.md
# vga_timing_detect

Sink-side counterpart of the VGA timing generator: monitors an incoming hsync/vsync/de stream clocked by `clk`. It measures horizontal and vertical timing, publishes per-frame measurements, and asserts `locked` once the timing is stable. It also regenerates pixel coordinates aligned to `de` for downstream capture logic. It sits between a video input (or a generator loop-back) and framebuffer/capture blocks.

## Interface
- `W`, 12: width of all counters and measurement outputs.
- `HS_POL`, 0: hsync active level (0 = active-low, 1 = active-high).
- `VS_POL`, 0: vsync active level (0 = active-low, 1 = active-high).
- `LOCK_FRAMES`, 2: consecutive matching frames required to assert `locked` (1..15).

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `hsync`  in  1  horizontal sync, synchronous to `clk`.
- `vsync`  in  1  vertical sync, synchronous to `clk`.
- `de`  in  1  data enable.
- `h_total`  out  W  clocks per line.
- `h_active`  out  W  `de`-high clocks per active line.
- `h_sync`  out  W  hsync-asserted clocks per line.
- `v_total`  out  W  lines per frame.
- `v_active`  out  W  lines containing `de` per frame.
- `v_sync`  out  W  lines whose leading hsync edge falls while vsync is asserted.
- `locked`  out  1  timing stable.
- `frame_start`  out  1  one-cycle pulse at each vsync leading edge.
- `de_o`  out  1  `de` delayed to align with `x`/`y`.
- `x`  out  W  pixel index within active line.
- `y`  out  W  active line index within frame.

## Operation
- Stage 1 registers the polarity-normalized inputs `hs1`, `vs1`, `de1`. Stage 2 registers `hs2` and `vs2`.
- `hs_edge = hs1 & ~hs2`. `vs_edge = vs1 & ~vs2`. A line ends at `hs_edge`; a frame ends at `vs_edge`.
- `pix_cnt` increments every clock and is cleared to 1 on `hs_edge`. On `hs_edge`, `line_total = pix_cnt`.
- `hs_cnt` counts clocks with `hs1` high and restarts at `hs_edge`. It is latched into `line_sync` on the next `hs_edge`.
- `de_cnt` counts `de1` clocks in the line. On `hs_edge`, it is latched into `line_active` only if nonzero, then cleared.
- Line counters (`ln_cnt`, `act_ln`, `vs_ln`) increment on `hs_edge`. `act_ln` increments only if the ending line had `de`; `vs_ln` increments only when `vs1` is high.
- Consistency: `line_err` sets if `line_total` differs between consecutive lines within a frame. The first line after `vs_edge` is not compared.
- All counters saturate at 2^W−1. Saturation sets `ovf` for the current frame.
- On `vs_edge`, snapshot `{line_total, line_active, line_sync, ln_cnt, act_ln, vs_ln}` into the six outputs, then clear the frame counters, `line_err` and `ovf`.
- The first `vs_edge` after reset only starts measurement; outputs keep their reset value and the snapshot is discarded.
- Lock state machine:
  - States: `SEARCH` → `TRACK` → `LOCKED`.
  - `match` means the new snapshot equals the previous one and the frame had no `line_err` and no `ovf`.
  - On each published frame:
    - `SEARCH`: go to `TRACK`, `good = 0`.
    - `TRACK`: if `match`, increment `good`; when `good` reaches `LOCK_FRAMES`, go to `LOCKED`. If not `match`, set `good = 0` and stay.
    - `LOCKED`: if not `match`, go to `TRACK` with `good = 0`.
  - `locked = (state == LOCKED)`.
  - No `vs_edge` within 2^W lines (`ln_cnt` saturated): return to `SEARCH` immediately.
- Coordinates:
  - `x` is cleared on a `de1` rising edge and increments while `de1` is high.
  - `y` is cleared on `vs_edge` and increments on the first `de1` falling edge of each line.
  - `x` and `y` are registered with `de_o = de1` delayed one clock.

## Timing
- Reset values: all measurement outputs, `x`, `y` = 0; `locked`, `frame_start`, `de_o` = 0; state = `SEARCH`.
- `de` → `de_o`: 2 clocks. The first active pixel has `x = 0`; the first active line has `y = 0`.
- `frame_start`: 2 clocks after the vsync input leading edge, 1 cycle wide. Measurement outputs update in the same cycle as `frame_start`.
- `locked` rises in the cycle after the snapshot that completes `LOCK_FRAMES` matches. With `LOCK_FRAMES = 2`, this is the 4th vsync edge after reset. It falls in the cycle after the first mismatching snapshot.
- `hsync` and `vsync` edges in the same clock: the line is closed first, then the frame, so the line counts toward the ending frame.
- Reset mid-frame: all state clears asynchronously; detection restarts from the first-edge rule.

## Test plan
- 1024x768@60 stimulus (line 1344, active 1024, hsync 136; frame 806, active 768, vsync 6), default polarity → at 4th vsync edge: h_total=1344, h_active=1024, h_sync=136, v_total=806, v_active=768, v_sync=6; `locked`=1.
- Same stream, x/y check → `de_o` 2 clocks after `de`; x runs 0..1023 per line; y runs 0..767; `frame_start` 2 clocks after each vsync falling edge.
- Locked, then one frame with h_total 1343 on line 100 → `locked`=0 after that frame; re-asserts after 2 further good frames.
- `HS_POL`=`VS_POL`=1 with inverted sync polarity → identical measurements and lock.
- vsync held inactive for more than 4096 lines → `locked`=0 immediately, state `SEARCH`; normal stream afterwards relocks on the 4th vsync edge.
- `rst_n` low mid-frame while locked → all outputs 0 asynchronously; relock on the 4th vsync edge after release.
